// File: rtl/svcs_frame_rx.sv
// svcs_frame_rx
// Receive end of the SVCS socket byte protocol. Consumes the framed byte
// stream (header, optional 4-byte LE size, LE payload) on a valid/ready byte
// channel and reassembles it into typed 32-bit words on a valid/ready word
// channel. Malformed headers, out-of-range sizes and stalled frames raise a
// one-cycle frame_err_o pulse with a sticky err_code_o.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_n_i      synchronous active-low reset
//   rx_valid_i   input byte valid
//   rx_data_i    input byte
//   rx_ready_o   byte accepted when rx_valid_i & rx_ready_o
//   out_valid_o  output word valid
//   out_ready_i  consumer accepts word
//   out_data_o   assembled word, little-endian byte order
//   out_type_o   frame type code of the current word
//   out_first_o  first word of a frame
//   out_last_o   last word of a frame
//   frame_err_o  one-cycle error pulse
//   err_code_o   1 bad type, 2 bad size, 3 timeout; held until next error
//   busy_o       high whenever the receiver is not idle
module svcs_frame_rx #(
  parameter int unsigned MAX_LEN = 256,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_ready_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_data_o,
  output logic [2:0]  out_type_o,
  output logic        out_first_o,
  output logic        out_last_o,
  output logic        frame_err_o,
  output logic [1:0]  err_code_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SIZE = 2'd1,
    ST_DATA = 2'd2,
    ST_EMIT = 2'd3
  } state_e;

  localparam logic [2:0]  T_BYTE    = 3'd1;
  localparam logic [2:0]  T_INT     = 3'd2;
  localparam logic [2:0]  T_INTV    = 3'd3;
  localparam logic [2:0]  T_STRING  = 3'd4;
  localparam logic [2:0]  T_REAL    = 3'd5;
  localparam logic [31:0] MAX_LEN_W = 32'(MAX_LEN);
  localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [2:0]  type_q;
  logic [1:0]  lane_q;
  logic [31:0] word_q;
  logic [31:0] size_q;
  // Remaining payload bytes of the frame (INTV sizes are scaled to bytes).
  logic [31:0] rem_q;
  logic [31:0] tmo_q;
  logic        first_q;

  logic        rx_ready_q;
  logic        out_valid_q;
  logic [31:0] out_data_q;
  logic [2:0]  out_type_q;
  logic        out_first_q;
  logic        out_last_q;
  logic        frame_err_q;
  logic [1:0]  err_code_q;
  logic        busy_q;

  logic        byte_acc_d;
  logic        hdr_valid_d;
  logic        hdr_bad_d;
  logic        size_bad_d;
  logic        tmo_hit_d;
  logic        word_done_d;
  logic        emit_hs_d;
  logic        count_idle_d;
  logic        len_ok_d;
  logic [31:0] size_d;
  logic [31:0] word_d;
  logic [31:0] rem_dec_d;

  // Next-state decode and frame events for the current cycle.
  always_comb begin
    state_d      = state_q;
    hdr_bad_d    = 1'b0;
    size_bad_d   = 1'b0;
    tmo_hit_d    = 1'b0;
    word_done_d  = 1'b0;
    emit_hs_d    = 1'b0;
    byte_acc_d   = rx_valid_i & rx_ready_q;
    hdr_valid_d  = (rx_data_i >= 8'd1) && (rx_data_i <= 8'd5);
    // Size bytes arrive LE: shift new byte in from the top.
    size_d       = {rx_data_i, size_q[31:8]};
    len_ok_d     = (size_d != 32'd0) && (size_d <= MAX_LEN_W);
    word_d       = word_q;
    word_d[{lane_q, 3'b000} +: 8] = rx_data_i;
    rem_dec_d    = rem_q - 32'd1;

    case (state_q)
      ST_IDLE: begin
        if (byte_acc_d) begin
          if (hdr_valid_d) begin
            if ((rx_data_i[2:0] == T_INTV) || (rx_data_i[2:0] == T_STRING)) begin
              state_d = ST_SIZE;
            end else begin
              state_d = ST_DATA;
            end
          end else begin
            hdr_bad_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SIZE: begin
        if (byte_acc_d) begin
          if (lane_q == 2'd3) begin
            if (len_ok_d) begin
              state_d = ST_DATA;
            end else begin
              size_bad_d = 1'b1;
              state_d    = ST_IDLE;
            end
          end else begin
            state_d = ST_SIZE;
          end
        end else if (tmo_q == TMO_LAST) begin
          tmo_hit_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_SIZE;
        end
      end
      ST_DATA: begin
        if (byte_acc_d) begin
          // Word closes on its 4th lane or on the frame's final byte.
          if ((lane_q == 2'd3) || (rem_q == 32'd1)) begin
            word_done_d = 1'b1;
            state_d     = ST_EMIT;
          end else begin
            state_d = ST_DATA;
          end
        end else if (tmo_q == TMO_LAST) begin
          tmo_hit_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_EMIT: begin
        if (out_ready_i) begin
          emit_hs_d = 1'b1;
          state_d   = (rem_q == 32'd0) ? ST_IDLE : ST_DATA;
        end else begin
          state_d = ST_EMIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The idle counter only runs while a frame is waiting on input bytes.
    count_idle_d = ((state_q == ST_SIZE) || (state_q == ST_DATA)) &&
                   !byte_acc_d && !tmo_hit_d;
  end

  // Frame state, datapath and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      type_q      <= 3'd0;
      lane_q      <= 2'd0;
      word_q      <= 32'd0;
      size_q      <= 32'd0;
      rem_q       <= 32'd0;
      tmo_q       <= 32'd0;
      first_q     <= 1'b0;
      rx_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
      out_type_q  <= 3'd0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= 2'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_ready_q  <= (state_d != ST_EMIT);
      busy_q      <= (state_d != ST_IDLE);
      frame_err_q <= hdr_bad_d | size_bad_d | tmo_hit_d;

      if (hdr_bad_d) begin
        err_code_q <= 2'd1;
      end else if (size_bad_d) begin
        err_code_q <= 2'd2;
      end else if (tmo_hit_d) begin
        err_code_q <= 2'd3;
      end else begin
        err_code_q <= err_code_q;
      end

      if (count_idle_d) begin
        tmo_q <= tmo_q + 32'd1;
      end else begin
        tmo_q <= 32'd0;
      end

      case (state_q)
        ST_IDLE: begin
          if (byte_acc_d && hdr_valid_d) begin
            type_q  <= rx_data_i[2:0];
            lane_q  <= 2'd0;
            word_q  <= 32'd0;
            size_q  <= 32'd0;
            first_q <= 1'b1;
            case (rx_data_i[2:0])
              T_BYTE:  rem_q <= 32'd1;
              T_INT:   rem_q <= 32'd4;
              T_REAL:  rem_q <= 32'd8;
              default: rem_q <= 32'd0;
            endcase
          end
        end
        ST_SIZE: begin
          if (byte_acc_d) begin
            size_q <= size_d;
            lane_q <= lane_q + 2'd1;
            if ((lane_q == 2'd3) && len_ok_d) begin
              // Bounded by MAX_LEN, so the x4 scaling cannot overflow.
              rem_q <= (type_q == T_INTV) ? {size_d[29:0], 2'b00} : size_d;
            end
          end
        end
        ST_DATA: begin
          if (byte_acc_d) begin
            word_q <= word_d;
            lane_q <= lane_q + 2'd1;
            rem_q  <= rem_dec_d;
            if (word_done_d) begin
              out_valid_q <= 1'b1;
              out_data_q  <= word_d;
              out_type_q  <= type_q;
              out_first_q <= first_q;
              out_last_q  <= (rem_q == 32'd1);
            end
          end
        end
        ST_EMIT: begin
          if (emit_hs_d) begin
            out_valid_q <= 1'b0;
            first_q     <= 1'b0;
            // Cleared so a short string tail is zero-padded.
            word_q      <= 32'd0;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx_ready_o  = rx_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_type_o  = out_type_q;
  assign out_first_o = out_first_q;
  assign out_last_o  = out_last_q;
  assign frame_err_o = frame_err_q;
  assign err_code_o  = err_code_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_svcs_frame_rx.sv
// Testbench for svcs_frame_rx: frame vectors from a table plus hand-written
// latency, back-pressure, timeout and reset sequences. Expected words and
// error codes are queued when a frame is driven and checked by a monitor.
module tb_svcs_frame_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_type;
  logic        out_first;
  logic        out_last;
  logic        frame_err;
  logic [1:0]  err_code;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [7:0]        nb;
    logic [191:0]      raw;
    logic [2:0]        nw;
    logic [2:0]        typ;
    logic [1:0]        err;
    logic [3:0][31:0]  w;
  } vec_t;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  typ;
    logic        first;
    logic        last;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] err_q[$];
  vec_t       vecs[$];
  exp_t       mon_e;
  logic [1:0] mon_c;

  always #5 clk = ~clk;

  svcs_frame_rx #(.MAX_LEN(16), .TIMEOUT(8)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .rx_valid_i  (rx_valid),
    .rx_data_i   (rx_data),
    .rx_ready_o  (rx_ready),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_type_o  (out_type),
    .out_first_o (out_first),
    .out_last_o  (out_last),
    .frame_err_o (frame_err),
    .err_code_o  (err_code),
    .busy_o      (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] nb, input logic [191:0] raw,
                              input logic [2:0] nw, input logic [2:0] typ,
                              input logic [1:0] err, input logic [31:0] w0,
                              input logic [31:0] w1, input logic [31:0] w2,
                              input logic [31:0] w3);
    vec_t v;
    v.nb = nb; v.raw = raw; v.nw = nw; v.typ = typ; v.err = err;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    return v;
  endfunction

  // Drive one byte and hold it until accepted; returns 1 time unit after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    while (!rx_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      n_cmp++;
      n_fail++;
      $display("FAIL rx_ready_wait: got 0 expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic push_expect(input vec_t v);
    exp_t e;
    if (v.err != 2'd0) begin
      err_q.push_back(v.err);
    end else begin
      for (int k = 0; k < int'(v.nw); k++) begin
        e.data  = v.w[k];
        e.typ   = v.typ;
        e.first = (k == 0);
        e.last  = (k == int'(v.nw) - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic send_vec(input vec_t v);
    for (int i = 0; i < int'(v.nb); i++) begin
      send_byte(v.raw[(int'(v.nb) - 1 - i) * 8 +: 8]);
    end
  endtask

  task automatic wait_idle(input string name);
    int g = 0;
    while ((exp_q.size() != 0 || err_q.size() != 0 || busy) && g < 60) begin
      @(posedge clk);
      #1;
      g++;
    end
    check(name, {61'd0, exp_q.size() == 0, err_q.size() == 0, busy}, {61'd0, 3'b110});
  endtask

  function automatic logic [63:0] out_vec();
    return {21'd0, rx_ready, out_valid, out_data, out_type, out_first, out_last,
            frame_err, err_code, busy};
  endfunction

  // Scoreboard monitor: sampled mid-cycle, a handshake completes on the next edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", {27'd0, out_data, out_type, out_first, out_last}, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("word", {27'd0, out_data, out_type, out_first, out_last}, {27'd0, mon_e});
      end
    end
    if (rst_n && frame_err) begin
      if (err_q.size() == 0) begin
        check("unexpected_err", {62'd0, err_code}, 64'd0);
      end else begin
        mon_c = err_q.pop_front();
        check("err_code", {62'd0, err_code}, {62'd0, mon_c});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    // Frame table: bytes left-to-right in wire order.
    vecs.push_back(mk(8'd10, 192'h04_05000000_48454C4C4F, 3'd2, 3'd4, 2'd0,
                      32'h4C4C4548, 32'h0000004F, 32'd0, 32'd0));
    vecs.push_back(mk(8'd1, 192'h07, 3'd0, 3'd0, 2'd1, 32'd0, 32'd0, 32'd0, 32'd0));
    vecs.push_back(mk(8'd2, 192'h01_AA, 3'd1, 3'd1, 2'd0, 32'h000000AA, 32'd0, 32'd0, 32'd0));
    vecs.push_back(mk(8'd1, 192'h00, 3'd0, 3'd0, 2'd1, 32'd0, 32'd0, 32'd0, 32'd0));
    vecs.push_back(mk(8'd1, 192'h06, 3'd0, 3'd0, 2'd1, 32'd0, 32'd0, 32'd0, 32'd0));
    vecs.push_back(mk(8'd5, 192'h03_00000000, 3'd0, 3'd0, 2'd2, 32'd0, 32'd0, 32'd0, 32'd0));
    vecs.push_back(mk(8'd5, 192'h04_11000000, 3'd0, 3'd0, 2'd2, 32'd0, 32'd0, 32'd0, 32'd0));
    vecs.push_back(mk(8'd5, 192'h03_01000001, 3'd0, 3'd0, 2'd2, 32'd0, 32'd0, 32'd0, 32'd0));
    vecs.push_back(mk(8'd9, 192'h05_0102030405060708, 3'd2, 3'd5, 2'd0,
                      32'h04030201, 32'h08070605, 32'd0, 32'd0));
    vecs.push_back(mk(8'd21, 192'h04_10000000_303132333435363738393A3B3C3D3E3F, 3'd4, 3'd4, 2'd0,
                      32'h33323130, 32'h37363534, 32'h3B3A3938, 32'h3F3E3D3C));
    vecs.push_back(mk(8'd9, 192'h03_01000000_EFBEADDE, 3'd1, 3'd3, 2'd0,
                      32'hDEADBEEF, 32'd0, 32'd0, 32'd0));
    vecs.push_back(mk(8'd9, 192'h04_04000000_61626364, 3'd1, 3'd4, 2'd0,
                      32'h64636261, 32'd0, 32'd0, 32'd0));

    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'd0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_values", out_vec(), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", out_vec(), {21'd0, 1'b1, 42'd0});

    // INT latency: word valid right after the completing byte is accepted.
    v = mk(8'd5, 192'h02_78563412, 3'd1, 3'd2, 2'd0, 32'h12345678, 32'd0, 32'd0, 32'd0);
    push_expect(v);
    send_byte(8'h02); send_byte(8'h78); send_byte(8'h56); send_byte(8'h34);
    check("int_not_early", {63'd0, out_valid}, 64'd0);
    send_byte(8'h12);
    check("int_latency", {62'd0, out_valid, rx_ready}, {62'd0, 2'b10});
    @(posedge clk);
    #1;
    check("int_emit_release", {62'd0, out_valid, rx_ready}, {62'd0, 2'b01});
    wait_idle("drain_int");

    for (int i = 0; i < vecs.size(); i++) begin
      push_expect(vecs[i]);
      send_vec(vecs[i]);
      wait_idle($sformatf("drain_vec%0d", i));
    end

    // INTV N=3 with the consumer stalled for 10 cycles on word 1.
    push_expect(mk(8'd17, 192'h03_03000000_11223344_55667788_99AABBCC, 3'd3, 3'd3, 2'd0,
                   32'h44332211, 32'h88776655, 32'hCCBBAA99, 32'd0));
    send_byte(8'h03); send_byte(8'h03); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check("stall_hold", {29'd0, rx_ready, out_valid, out_data, frame_err, busy},
            {29'd0, 1'b0, 1'b1, 32'h88776655, 1'b0, 1'b1});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("stall_release", {62'd0, out_valid, rx_ready}, {62'd0, 2'b01});
    send_byte(8'h99); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    wait_idle("drain_stall");

    // Timeout: 8 idle cycles mid-INT aborts with code 3 and no word.
    err_q.push_back(2'd3);
    send_byte(8'h02); send_byte(8'h11); send_byte(8'h22);
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    check("tmo_not_yet", {62'd0, frame_err, busy}, {62'd0, 2'b01});
    @(posedge clk);
    #1;
    check("tmo_fire", {59'd0, frame_err, err_code, busy, out_valid},
          {59'd0, 1'b1, 2'd3, 1'b0, 1'b0});
    wait_idle("drain_tmo");

    // Reset in the middle of a REAL payload, then a clean REAL frame.
    send_byte(8'h05); send_byte(8'hE1); send_byte(8'hE2); send_byte(8'hE3);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midframe_reset", out_vec(), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release", out_vec(), {21'd0, 1'b1, 42'd0});
    v = mk(8'd9, 192'h05_1011121314151617, 3'd2, 3'd5, 2'd0,
           32'h13121110, 32'h17161514, 32'd0, 32'd0);
    push_expect(v);
    send_vec(v);
    wait_idle("drain_real_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
